// File: rtl/clk_meas_if.sv
// Measurement bus for clk_meas: slow input signal in, period/high-time results out.
// master = stimulus/consumer side, slave = measuring block.
interface clk_meas_if #(
    parameter int CNT_W = 24
);
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_len;
    logic             valid;
    logic             locked;
    logic             timeout;

    modport master (
        output sig_in,
        input  period, high_len, valid, locked, timeout
    );

    modport slave (
        input  sig_in,
        output period, high_len, valid, locked, timeout
    );
endinterface

// File: rtl/clk_meas.sv
// Measures period and high time of a slow square wave in clk cycles (high time only with CLK_MEAS_DUTY_EN).
// Latency: edges seen 3 clk after they occur; valid registered on the detected rise.
// Backpressure: none; results and the valid strobe are fire-and-forget.
module clk_meas #(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 5000000,
    parameter int LOCK_N  = 4
) (
    input  logic        clk,
    input  logic        rst,
    clk_meas_if.slave   bus
);
    typedef enum logic {IDLE, MEAS} state_t;

    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_M1 = 4'(LOCK_N - 1);

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise;
    logic             start, meas_done, tmo_hit;
    logic [CNT_W-1:0] cnt, prev_period, period_q;
    logic             prev_vld;
    logic [3:0]       mcnt, mcnt_inc;
    logic             valid_q, locked_q, timeout_q;

    // Two-flop synchronizer plus history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign mcnt_inc = (mcnt == LOCK_M1) ? mcnt : mcnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        meas_done = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: if (rise) begin
                state_nxt = MEAS;
                start     = 1'b1;
            end
            MEAS: begin
                // A rise on the very cycle cnt reaches TIMEOUT is still a valid period.
                if (rise) begin
                    meas_done = 1'b1;
                end else if (cnt == TMO_CNT) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            prev_period <= '0;
            period_q    <= '0;
            prev_vld    <= 1'b0;
            mcnt        <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start) begin
                cnt       <= CNT_W'(1);
                timeout_q <= 1'b0;
                prev_vld  <= 1'b0;
            end else if (tmo_hit) begin
                cnt       <= '0;
                timeout_q <= 1'b1;
                locked_q  <= 1'b0;
                mcnt      <= '0;
            end else if (meas_done) begin
                cnt         <= CNT_W'(1);
                period_q    <= cnt;
                valid_q     <= 1'b1;
                prev_period <= cnt;
                prev_vld    <= 1'b1;
                // The first period after IDLE only seeds prev_period.
                if (prev_vld) begin
                    if (cnt == prev_period) begin
                        mcnt     <= mcnt_inc;
                        locked_q <= (mcnt_inc == LOCK_M1);
                    end else begin
                        mcnt     <= '0;
                        locked_q <= 1'b0;
                    end
                end
            end else if (state == MEAS) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef CLK_MEAS_DUTY_EN
    logic             fall;
    logic [CNT_W-1:0] hcnt, hl_cap, high_len_q;

    assign fall = ~s2 & s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt       <= '0;
            hl_cap     <= '0;
            high_len_q <= '0;
        end else begin
            if (start) begin
                hcnt <= CNT_W'(1);
            end else if (tmo_hit) begin
                hcnt <= '0;
            end else if (meas_done) begin
                hcnt       <= CNT_W'(1);
                high_len_q <= hl_cap;
            end else if (state == MEAS && s2) begin
                hcnt <= hcnt + CNT_W'(1);
            end
            if (state == MEAS && fall) hl_cap <= hcnt;
        end
    end

    assign bus.high_len = high_len_q;
`else
    assign bus.high_len = '0;
`endif

    assign bus.period  = period_q;
    assign bus.valid   = valid_q;
    assign bus.locked  = locked_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_clk_meas.sv
// Directed bench for clk_meas: periods, duty, lock/unlock, timeout and mid-period reset.
module tb_clk_meas;
`ifdef CLK_MEAS_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    typedef struct {
        int per;
        int hl;
        bit lk;
        bit tmo;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    ev_t  evq[$];
    int   tmoq[$];
    ev_t  ev_tmp;
    bit   tmo_prev = 1'b0;

    clk_meas_if #(.CNT_W(24)) bus ();

    clk_meas #(.CNT_W(24), .TIMEOUT(100), .LOCK_N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid strobe and every timeout assertion with its cycle stamp.
    always @(negedge clk) begin
        if (bus.valid) begin
            ev_tmp.per = int'(bus.period);
            ev_tmp.hl  = int'(bus.high_len);
            ev_tmp.lk  = bus.locked;
            ev_tmp.tmo = bus.timeout;
            ev_tmp.cyc = cyc;
            evq.push_back(ev_tmp);
        end
        if (bus.timeout && !tmo_prev) tmoq.push_back(cyc);
        tmo_prev = bus.timeout;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input int hi, input int lo, input int n);
        repeat (n) begin
            bus.sig_in = 1'b1;
            tick(hi);
            bus.sig_in = 1'b0;
            tick(lo);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic chk_ev(input string tag, input int idx, input int per,
                          input int hl, input int lk);
        if (idx < evq.size()) begin
            chk($sformatf("%s_per%0d", tag, idx), evq[idx].per, per);
            chk($sformatf("%s_hl%0d", tag, idx), evq[idx].hl, DUTY ? hl : 0);
            chk($sformatf("%s_lk%0d", tag, idx), int'(evq[idx].lk), lk);
            chk($sformatf("%s_tmo%0d", tag, idx), int'(evq[idx].tmo), 0);
        end else begin
            chk($sformatf("%s_missing%0d", tag, idx), 0, 1);
        end
    endtask

    int base;
    int tbase;
    int exp_per[11] = '{18, 18, 18, 18, 18, 20, 18, 18, 18, 18, 18};
    int exp_hl [11] = '{9, 9, 9, 9, 9, 10, 9, 9, 9, 9, 9};
    int exp_lk [11] = '{0, 0, 0, 1, 1, 0, 0, 0, 1 - 1, 1, 1};

    initial begin
        bus.sig_in = 1'b0;
        tick(3);
        chk("rst_period",  int'(bus.period), 0);
        chk("rst_high",    int'(bus.high_len), 0);
        chk("rst_valid",   int'(bus.valid), 0);
        chk("rst_locked",  int'(bus.locked), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
        rst = 1'b0;
        tick(2);

        // 9/9 toggling: 6 rises -> 5 valids, lock on the 4th
        base = evq.size();
        run(9, 9, 6);
        tick(5);
        chk("t9_nval", evq.size() - base, 5);
        for (int i = 0; i < 5; i++) chk_ev("t9", base + i, 18, 9, (i >= 3) ? 1 : 0);
        do_reset();

        // 4/4 toggling
        base = evq.size();
        run(4, 4, 6);
        tick(5);
        chk("t4_nval", evq.size() - base, 5);
        for (int i = 0; i < 5; i++) chk_ev("t4", base + i, 8, 4, (i >= 3) ? 1 : 0);
        do_reset();

        // 20 high / 10 low
        base = evq.size();
        run(20, 10, 3);
        tick(5);
        chk("t30_nval", evq.size() - base, 2);
        for (int i = 0; i < 2; i++) chk_ev("t30", base + i, 30, 20, 0);
        do_reset();

        // Period exactly TIMEOUT: rise and cnt==TIMEOUT coincide, rise wins
        base  = evq.size();
        tbase = tmoq.size();
        run(50, 50, 2);
        bus.sig_in = 1'b1;
        tick(5);
        chk("t100_nval", evq.size() - base, 2);
        for (int i = 0; i < 2; i++) chk_ev("t100", base + i, 100, 50, 0);
        chk("t100_no_tmo", tmoq.size() - tbase, 0);
        bus.sig_in = 1'b0;
        do_reset();

        // Lock, break with one 20-clk period, re-lock
        base = evq.size();
        run(9, 9, 5);
        run(10, 10, 1);
        run(9, 9, 6);
        chk("brk_nval", evq.size() - base, 11);
        for (int i = 0; i < 11; i++) chk_ev("brk", base + i, exp_per[i], exp_hl[i], exp_lk[i]);

        // sig_in held low: timeout exactly 100 cycles after the last valid
        tbase = tmoq.size();
        tick(100);
        chk("tmo_cnt", tmoq.size() - tbase, 1);
        if (tmoq.size() > tbase && evq.size() > 0)
            chk("tmo_delay", tmoq[tbase] - evq[evq.size() - 1].cyc, 100);
        else
            chk("tmo_delay_missing", 0, 1);
        chk("tmo_flag",   int'(bus.timeout), 1);
        chk("tmo_locked", int'(bus.locked), 0);
        chk("tmo_noval",  evq.size() - base, 11);
        bus.sig_in = 1'b1;
        tick(9);
        chk("tmo_clear",  int'(bus.timeout), 0);
        chk("tmo_noval2", evq.size() - base, 11);
        bus.sig_in = 1'b0;
        tick(9);
        run(9, 9, 1);
        chk("tmo_nval3", evq.size() - base, 12);
        chk_ev("tmo_after", base + 11, 18, 9, 0);

        // Reset in the middle of a high phase
        run(9, 9, 3);
        bus.sig_in = 1'b1;
        tick(4);
        rst   = 1'b1;
        base  = evq.size();
        bus.sig_in = 1'b0;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            chk("mid_period", int'(bus.period), 0);
            chk("mid_high",   int'(bus.high_len), 0);
            chk("mid_locked", int'(bus.locked), 0);
            chk("mid_tmo",    int'(bus.timeout), 0);
            tick(1);
        end
        chk("mid_noval", evq.size() - base, 0);
        rst = 1'b0;
        tick(2);
        run(9, 9, 1);
        chk("rel_noval", evq.size() - base, 0);
        run(9, 9, 2);
        chk("rel_nval", evq.size() - base, 2);
        chk_ev("rel", base, 18, 9, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
